// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight writer shadow, operand forwarding selects and load-use stall
// Slot j mirrors the pipeline register EX+j; a registered select of j+1 picks that stage's result.

module hazard_scoreboard #(
  parameter int NSRC  = 2,
  parameter int REGW  = 5,
  parameter int DEPTH = 2,
  parameter int SELW  = $clog2(DEPTH + 1),
  parameter int CNTW  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [NSRC*REGW-1:0]   id_rs,
  input  logic [NSRC-1:0]        id_rs_used,
  input  logic [REGW-1:0]        id_rd,
  input  logic                   id_regwrite,
  input  logic [SELW-1:0]        id_lat,
  input  logic                   fwd_en,
  input  logic                   hold,
  input  logic                   flush,
  output logic                   stall,
  output logic [NSRC*SELW-1:0]   fwd_sel,
  output logic [CNTW-1:0]        stall_cnt
);

  logic [DEPTH-1:0] slot_valid;
  logic [REGW-1:0]  slot_rd  [DEPTH];
  logic [SELW-1:0]  slot_lat [DEPTH];

  logic [NSRC-1:0]  hit;
  logic [NSRC-1:0]  ready;
  logic [SELW-1:0]  young_sel [NSRC];
  logic             need_stall;

  // Slots are scanned oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      hit[i]       = 1'b0;
      ready[i]     = 1'b0;
      young_sel[i] = '0;
      for (int j = DEPTH - 1; j >= 0; j--) begin
        if (id_valid && id_rs_used[i] && slot_valid[j] && (slot_rd[j] != '0) &&
            (slot_rd[j] == id_rs[i*REGW +: REGW])) begin
          hit[i]       = 1'b1;
          young_sel[i] = SELW'(j + 1);
          ready[i]     = (slot_lat[j] == '0) || (slot_lat[j] <= SELW'(j + 1));
        end
      end
    end
  end

  always_comb begin
    need_stall = fwd_en ? |(hit & ~ready) : |hit;
    stall      = need_stall && id_valid && !flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        slot_rd[j]  <= '0;
        slot_lat[j] <= '0;
      end
      fwd_sel   <= '0;
      stall_cnt <= '0;
    end else if (!hold) begin
      for (int j = DEPTH - 1; j > 0; j--) begin
        slot_valid[j] <= slot_valid[j-1];
        slot_rd[j]    <= slot_rd[j-1];
        slot_lat[j]   <= slot_lat[j-1];
      end
      if (id_valid && id_regwrite && !stall && !flush) begin
        slot_valid[0] <= 1'b1;
        slot_rd[0]    <= id_rd;
        slot_lat[0]   <= id_lat;
      end else begin
        slot_valid[0] <= 1'b0;
        slot_rd[0]    <= '0;
        slot_lat[0]   <= '0;
      end
      for (int i = 0; i < NSRC; i++) begin
        fwd_sel[i*SELW +: SELW] <= (fwd_en && hit[i] && !stall && !flush) ? young_sel[i] : '0;
      end
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed vector table plus hold/flush, saturation and reset sequences
// A narrow counter keeps the saturation sequence short.

module tb_hazard_scoreboard;

  localparam int NSRC = 2;
  localparam int REGW = 5;
  localparam int DEPTH = 2;
  localparam int SELW = 2;
  localparam int CNTW = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 id_valid;
  logic [NSRC*REGW-1:0] id_rs;
  logic [NSRC-1:0]      id_rs_used;
  logic [REGW-1:0]      id_rd;
  logic                 id_regwrite;
  logic [SELW-1:0]      id_lat;
  logic                 fwd_en;
  logic                 hold;
  logic                 flush;
  logic                 stall;
  logic [NSRC*SELW-1:0] fwd_sel;
  logic [CNTW-1:0]      stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_scoreboard #(.NSRC(NSRC), .REGW(REGW), .DEPTH(DEPTH), .SELW(SELW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_lat(id_lat), .fwd_en(fwd_en),
    .hold(hold), .flush(flush), .stall(stall), .fwd_sel(fwd_sel), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic [1:0] used;
    logic [4:0] rd;
    logic       we;
    logic [1:0] lat;
    logic       fen;
    logic       e_stall;
    logic [3:0] e_sel;
    int         e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used,
                     input logic [4:0] rd, input logic we, input logic [1:0] lat, input logic fen,
                     input logic e_stall, input logic [3:0] e_sel, input int e_cnt);
    vec_t r;
    r.v = v; r.rs0 = rs0; r.rs1 = rs1; r.used = used; r.rd = rd; r.we = we; r.lat = lat;
    r.fen = fen; r.e_stall = e_stall; r.e_sel = e_sel; r.e_cnt = e_cnt;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used,
                       input logic [4:0] rd, input logic we, input logic [1:0] lat, input logic fen);
    id_valid = v; id_rs = {rs1, rs0}; id_rs_used = used; id_rd = rd;
    id_regwrite = we; id_lat = lat; fwd_en = fen;
  endtask

  task automatic check3(input string tag, input int e_stall, input int e_sel, input int e_cnt);
    chk({tag, " stall"}, int'(stall), e_stall);
    chk({tag, " fwd_sel"}, int'(fwd_sel), e_sel);
    chk({tag, " stall_cnt"}, int'(stall_cnt), e_cnt);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 1);

    //  v rs0 rs1 used rd we lat fen | stall sel cnt   (sel = {src1,src0})
    add(1, 0, 0, 2'b00, 5, 1, 1, 1,  0, 4'h0, 0);  // ALU writer r5
    add(1, 5, 0, 2'b01, 0, 0, 0, 1,  0, 4'h0, 0);  // back-to-back consumer
    add(0, 0, 0, 2'b00, 0, 0, 0, 1,  0, 4'h1, 0);
    add(1, 0, 0, 2'b00, 7, 1, 2, 1,  0, 4'h0, 0);  // load r7
    add(1, 0, 7, 2'b10, 0, 0, 0, 1,  1, 4'h0, 0);  // load-use
    add(1, 0, 7, 2'b10, 0, 0, 0, 1,  0, 4'h0, 1);
    add(0, 0, 0, 2'b00, 0, 0, 0, 1,  0, 4'h8, 1);
    add(1, 0, 0, 2'b00, 3, 1, 1, 1,  0, 4'h0, 1);  // r3 twice
    add(1, 0, 0, 2'b00, 3, 1, 1, 1,  0, 4'h0, 1);
    add(1, 3, 3, 2'b11, 0, 0, 0, 1,  0, 4'h0, 1);  // youngest wins, equal selects
    add(0, 0, 0, 2'b00, 0, 0, 0, 1,  0, 4'h5, 1);
    add(1, 0, 0, 2'b00, 3, 1, 1, 1,  0, 4'h0, 1);
    add(1, 0, 0, 2'b00, 3, 1, 1, 1,  0, 4'h0, 1);
    add(1, 0, 0, 2'b11, 0, 0, 0, 1,  0, 4'h0, 1);  // r0 never matches
    add(0, 0, 0, 2'b00, 0, 0, 0, 1,  0, 4'h0, 1);
    add(1, 0, 0, 2'b00, 4, 1, 1, 1,  0, 4'h0, 1);  // r4 then r6
    add(1, 0, 0, 2'b00, 6, 1, 1, 1,  0, 4'h0, 1);
    add(1, 4, 6, 2'b11, 0, 0, 0, 1,  0, 4'h0, 1);  // independent sources
    add(0, 0, 0, 2'b00, 0, 0, 0, 1,  0, 4'h6, 1);
    add(1, 0, 0, 2'b00, 9, 1, 1, 0,  0, 4'h0, 1);  // interlock mode
    add(1, 9, 0, 2'b01, 0, 0, 0, 0,  1, 4'h0, 1);
    add(1, 9, 0, 2'b01, 0, 0, 0, 0,  1, 4'h0, 2);
    add(1, 9, 0, 2'b01, 0, 0, 0, 0,  0, 4'h0, 3);
    add(0, 0, 0, 2'b00, 0, 0, 0, 0,  0, 4'h0, 3);
    add(1, 0, 0, 2'b00, 10, 1, 0, 1, 0, 4'h0, 3);  // lat 0 acts as 1
    add(1, 10, 0, 2'b01, 0, 0, 0, 1, 0, 4'h0, 3);
    add(0, 0, 0, 2'b00, 0, 0, 0, 1,  0, 4'h1, 3);
    add(1, 0, 0, 2'b00, 11, 1, 3, 1, 0, 4'h0, 3);  // lat beyond DEPTH
    add(1, 0, 11, 2'b10, 0, 0, 0, 1, 1, 4'h0, 3);
    add(1, 0, 11, 2'b10, 0, 0, 0, 1, 1, 4'h0, 4);
    add(1, 0, 11, 2'b10, 0, 0, 0, 1, 0, 4'h0, 5);
    add(0, 0, 0, 2'b00, 0, 0, 0, 1,  0, 4'h0, 5);
    add(1, 0, 0, 2'b00, 12, 1, 2, 1, 0, 4'h0, 5);  // invalid ID never stalls
    add(0, 12, 0, 2'b01, 0, 0, 0, 1, 0, 4'h0, 5);
    add(0, 0, 0, 2'b00, 0, 0, 0, 1,  0, 4'h0, 5);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check3("reset", 0, 0, 0);
    next_cycle();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].rs0, tbl[i].rs1, tbl[i].used, tbl[i].rd, tbl[i].we, tbl[i].lat, tbl[i].fen);
      @(negedge clk);
      check3($sformatf("vec%0d", i), int'(tbl[i].e_stall), int'(tbl[i].e_sel), tbl[i].e_cnt);
      next_cycle();
    end

    // Hold while stalled, then flush the stalled consumer.
    drive(1, 0, 0, 2'b00, 13, 1, 1, 1);
    next_cycle();
    drive(1, 0, 13, 2'b10, 7, 1, 2, 1);
    next_cycle();
    drive(1, 7, 0, 2'b01, 7, 1, 2, 1);
    hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check3($sformatf("hold%0d", k), 1, 4, 5);
      next_cycle();
    end
    hold = 1'b0; flush = 1'b1;
    @(negedge clk);
    check3("flush", 0, 4, 5);
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    check3("post_flush", 0, 0, 5);
    next_cycle();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 1);
    @(negedge clk);
    check3("post_flush_fwd", 0, 2, 5);
    next_cycle();

    // Saturation: fixed self-dependent lat-3 writer stalls two of every three cycles.
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    drive(1, 1, 0, 2'b01, 1, 1, 3, 1);
    repeat (30) next_cycle();
    chk("cnt_mid", int'(stall_cnt), 20);
    repeat (400) next_cycle();
    chk("cnt_sat", int'(stall_cnt), 255);
    chk("stall_before_rst", int'(stall), 1);
    #1 rst_n = 1'b0;
    #1;
    check3("async_rst", 0, 0, 0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check3("after_rst", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
